spi_xfer_arbiter: RTL and testbench

SPI_XFER_ARBITER -- requirements
Module: spi_xfer_arbiter

---
 rtl/spi_arb_pkg.sv | 17 +
 rtl/spi_rr_picker.sv | 37 +++
 rtl/spi_xfer_arbiter.sv | 178 +++++++++++++++++
 tb/tb_spi_xfer_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_arb_pkg.sv
// Shared types and default sizing for the SPI transfer arbiter.
package spi_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        BUSY,
        DRAIN,
        GAP
    } arb_state_e;

    localparam int DEF_NUM_REQ        = 4;
    localparam int DEF_DATA_WIDTH     = 512;
    localparam int DEF_GAP_CYCLES     = 2;
    localparam int DEF_TIMEOUT_CYCLES = 65535;

endpackage

// File: rtl/spi_rr_picker.sv
// Round-robin winner selection: first asserted request at or after ptr_i, wrapping.
module spi_rr_picker
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
    output logic                       valid_o,
    output logic [$clog2(NUM_REQ)-1:0] idx_o
);

    localparam int IW = $clog2(NUM_REQ);

    int            cand;
    logic [IW-1:0] cand_idx;

    // Scan from farthest to nearest so the candidate closest to ptr_i is written last.
    always_comb begin
        valid_o  = 1'b0;
        idx_o    = '0;
        cand     = 0;
        cand_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = int'(ptr_i) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IW'(cand);
            if (req_i[cand_idx]) begin
                valid_o = 1'b1;
                idx_o   = cand_idx;
            end
        end
    end

endmodule

// File: rtl/spi_xfer_arbiter.sv
// Shares one SPI master among NUM_REQ requesters with round-robin arbitration.
// Define SPI_ARB_TIMEOUT_EN to add a watchdog that aborts stuck transfers via err_o.
module spi_xfer_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] data_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic [NUM_REQ-1:0]            done_o,
    output logic [NUM_REQ-1:0]            err_o,
    output logic                          spi_start_o,
    output logic [DATA_WIDTH-1:0]         spi_data_o,
    input  logic                          spi_finish_i,
    output logic                          busy_o,
    output logic [$clog2(NUM_REQ)-1:0]    cur_id_o
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    arb_state_e                          state_q, state_d;
    logic [IW-1:0]                       ptr_q, ptr_d;
    logic [IW-1:0]                       cur_id_q, cur_id_d;
    logic [DATA_WIDTH-1:0]               data_q, data_d;
    logic                                start_q, start_d;
    logic                                busy_q, busy_d;
    logic [NUM_REQ-1:0]                  gnt_q, gnt_d;
    logic [NUM_REQ-1:0]                  done_q, done_d;
    logic [GW-1:0]                       gap_q, gap_d;
    logic                                pick_valid;
    logic [IW-1:0]                       pick_idx;
    logic                                tmo_hit;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  slices;

    assign slices = data_i;

    spi_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0]      tmo_q, tmo_d;
    logic [NUM_REQ-1:0] err_q, err_d;

    assign tmo_hit = ((state_q == BUSY) || (state_q == DRAIN)) &&
                     (int'(tmo_q) == TIMEOUT_CYCLES - 1);

    // Watchdog spans BUSY and DRAIN together; it restarts on every new grant.
    always_comb begin
        tmo_d = tmo_q;
        err_d = '0;
        if (state_q == START) begin
            tmo_d = '0;
        end else if (tmo_hit) begin
            err_d[cur_id_q] = 1'b1;
        end else if ((state_q == BUSY) || (state_q == DRAIN)) begin
            tmo_d = tmo_q + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
            err_q <= '0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    logic unused_tmo_cfg;

    assign unused_tmo_cfg = (TIMEOUT_CYCLES == 0);
    assign tmo_hit        = 1'b0;
    assign err_o          = '0;
`endif

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cur_id_d = cur_id_q;
        data_d   = data_q;
        start_d  = 1'b0;
        gnt_d    = '0;
        done_d   = '0;
        gap_d    = gap_q;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d         = START;
                    cur_id_d        = pick_idx;
                    data_d          = slices[pick_idx];
                    start_d         = 1'b1;
                    gnt_d[pick_idx] = 1'b1;
                end
            end
            START: begin
                ptr_d   = (cur_id_q == IW'(NUM_REQ - 1)) ? '0 : cur_id_q + IW'(1);
                state_d = BUSY;
            end
            BUSY, DRAIN: begin
                // A finished or aborted transfer skips GAP entirely when no gap is configured.
                if (tmo_hit || ((state_q == DRAIN) && !spi_finish_i)) begin
                    if (!tmo_hit) begin
                        done_d[cur_id_q] = 1'b1;
                    end
                    gap_d = '0;
                    if (GAP_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = GAP;
                    end
                end else if ((state_q == BUSY) && spi_finish_i) begin
                    state_d = DRAIN;
                end
            end
            GAP: begin
                if (int'(gap_q) == GAP_CYCLES - 1) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            cur_id_q <= '0;
            data_q   <= '0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            gnt_q    <= '0;
            done_q   <= '0;
            gap_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cur_id_q <= cur_id_d;
            data_q   <= data_d;
            start_q  <= start_d;
            busy_q   <= busy_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            gap_q    <= gap_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign done_o      = done_q;
    assign spi_start_o = start_q;
    assign spi_data_o  = data_q;
    assign busy_o      = busy_q;
    assign cur_id_o    = cur_id_q;

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Self-checking bench for spi_xfer_arbiter: vector table plus hand-written reset,
// rotation and (with SPI_ARB_TIMEOUT_EN) watchdog sequences, using a grant scoreboard.
module tb_spi_xfer_arbiter;

    localparam int NR         = 4;
    localparam int DW         = 512;
    localparam int GAP_N      = 2;
    localparam int TMO        = 100;
    localparam int SLAVE_LAT  = 20;
    localparam int FINISH_LEN = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_i;
    logic [NR*DW-1:0]  data_i;
    logic [NR-1:0]     gnt_o;
    logic [NR-1:0]     done_o;
    logic [NR-1:0]     err_o;
    logic              spi_start_o;
    logic [DW-1:0]     spi_data_o;
    logic              spi_finish_i;
    logic              busy_o;
    logic [1:0]        cur_id_o;

    typedef struct {
        int            id;
        logic [DW-1:0] data;
    } exp_t;

    typedef struct {
        logic [NR-1:0] req;
        logic [31:0]   pay;
        logic [7:0]    order;
        int            n;
    } vec_t;

    exp_t          sb_q[$];
    vec_t          vecs[5];
    int            n_checks = 0;
    int            n_fail = 0;
    int            cycle = 0;
    int            grants_seen, dones, errs;
    int            start_cycle, first_gnt_cycle, last_done_cycle, last_err_cycle;
    int            min_gap, max_gap;
    int            slave_cnt, fin_cnt, cur_owner;
    bit            in_xfer, hold_mode, slave_en, expect_err;
    logic [DW-1:0] slave_data;

    spi_xfer_arbiter #(
        .NUM_REQ        (NR),
        .DATA_WIDTH     (DW),
        .GAP_CYCLES     (GAP_N),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_i        (req_i),
        .data_i       (data_i),
        .gnt_o        (gnt_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .spi_start_o  (spi_start_o),
        .spi_data_o   (spi_data_o),
        .spi_finish_i (spi_finish_i),
        .busy_o       (busy_o),
        .cur_id_o     (cur_id_o)
    );

    // 50 MHz system clock
    always #10 clk = ~clk;

    function automatic logic [NR-1:0] onehot(input int id);
        logic [NR-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    function automatic vec_t mkVec(input logic [NR-1:0] req, input logic [31:0] pay,
                                   input logic [7:0] order, input int n);
        vec_t v;
        v.req   = req;
        v.pay   = pay;
        v.order = order;
        v.n     = n;
        return v;
    endfunction

    function automatic logic [DW-1:0] payOf(input logic [31:0] pay, input int k);
        logic [31:0] p;
        p = pay >> (8 * k);
        return DW'(p[7:0]);
    endfunction

    function automatic int orderOf(input logic [7:0] order, input int j);
        logic [7:0] o;
        o = order >> (2 * j);
        return int'(o[1:0]);
    endfunction

    task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    task automatic resetTrack();
        grants_seen = 0;
        dones       = 0;
        errs        = 0;
        min_gap     = 1000000;
        max_gap     = -1;
        start_cycle = cycle;
    endtask

    // One clock of bench activity, sampled at the falling edge: slave model, grant
    // scoreboard, completion and error tracking, and requester release on grant.
    task automatic tick();
        exp_t e;
        int   g;
        @(negedge clk);
        cycle++;
        checkOutput("pulse_onehot", ($countones(gnt_o) + $countones(done_o) + $countones(err_o)) <= 1, 1);
        if (slave_en) begin
            if (slave_cnt > 0) begin
                slave_cnt--;
                if (slave_cnt == 0) begin
                    spi_finish_i = 1'b1;
                    fin_cnt      = FINISH_LEN;
                end
            end else if (fin_cnt > 0) begin
                fin_cnt--;
                if (fin_cnt == 0) spi_finish_i = 1'b0;
            end
        end
        if (gnt_o != '0) begin
            if (sb_q.size() == 0) begin
                checkOutput("unexpected_gnt", gnt_o, '0);
            end else begin
                e = sb_q.pop_front();
                checkOutput("gnt_id", gnt_o, onehot(e.id));
                checkOutput("start_with_gnt", spi_start_o, 1);
                checkOutput("spi_data", spi_data_o, e.data);
                checkOutput("cur_id", cur_id_o, e.id);
                if (grants_seen == 0) begin
                    first_gnt_cycle = cycle;
                end else begin
                    g = cycle - last_done_cycle;
                    if (g < min_gap) min_gap = g;
                    if (g > max_gap) max_gap = g;
                end
                grants_seen++;
                cur_owner  = e.id;
                in_xfer    = 1'b1;
                slave_data = spi_data_o;
                slave_cnt  = SLAVE_LAT;
                if (!hold_mode) req_i[e.id] = 1'b0;
                else if (sb_q.size() == 0) req_i = '0;
            end
        end else if (spi_start_o) begin
            checkOutput("start_without_gnt", spi_start_o, 0);
        end
        if (done_o != '0) begin
            checkOutput("done_id", done_o, in_xfer ? onehot(cur_owner) : '0);
            checkOutput("data_stable", spi_data_o, slave_data);
            in_xfer         = 1'b0;
            dones++;
            last_done_cycle = cycle;
        end
        if (err_o != '0) begin
            checkOutput("err_id", err_o, (expect_err && in_xfer) ? onehot(cur_owner) : '0);
            in_xfer        = 1'b0;
            errs++;
            last_err_cycle = cycle;
        end
    endtask

    task automatic waitIdle(input string name, input int budget);
        int k;
        k = 0;
        while ((sb_q.size() != 0 || in_xfer || busy_o || req_i != '0) && k < budget) begin
            tick();
            k++;
        end
        checkOutput({name, "_bounded"}, k < budget, 1);
    endtask

    task automatic applyStimulus(input vec_t v, input string name);
        exp_t e;
        for (int k = 0; k < NR; k++) data_i[k*DW +: DW] = payOf(v.pay, k);
        resetTrack();
        req_i = v.req;
        for (int j = 0; j < v.n; j++) begin
            e.id   = orderOf(v.order, j);
            e.data = payOf(v.pay, e.id);
            sb_q.push_back(e);
        end
        waitIdle(name, 1000);
        checkOutput({name, "_grants"}, grants_seen, v.n);
        checkOutput({name, "_dones"}, dones, v.n);
        checkOutput({name, "_latency"}, first_gnt_cycle - start_cycle, 1);
        if (v.n >= 2) begin
            checkOutput({name, "_gap_min"}, min_gap, GAP_N + 1);
            checkOutput({name, "_gap_max"}, max_gap, GAP_N + 1);
        end
    endtask

    initial begin
        exp_t e;
        int   k;
        rst_n        = 1'b0;
        req_i        = '0;
        data_i       = '0;
        spi_finish_i = 1'b0;
        in_xfer      = 1'b0;
        hold_mode    = 1'b0;
        slave_en     = 1'b1;
        expect_err   = 1'b0;
        slave_cnt    = 0;
        fin_cnt      = 0;
        cur_owner    = 0;
        slave_data   = '0;
        last_done_cycle = 0;
        last_err_cycle  = 0;
        first_gnt_cycle = 0;
        resetTrack();

        // {req}, {slot3..slot0 payload bytes}, {grant order, 2 bits each, first in LSBs}, count
        vecs[0] = mkVec(4'b0001, 32'h0000_0035, 8'h00, 1);
        vecs[1] = mkVec(4'b1010, 32'h5500_4400, 8'h0D, 2);
        vecs[2] = mkVec(4'b0101, 32'h00A2_00A0, 8'h08, 2);
        vecs[3] = mkVec(4'b1111, 32'hD3D2_D1D0, 8'h93, 4);
        vecs[4] = mkVec(4'b0100, 32'h00E2_0000, 8'h02, 1);

        repeat (3) @(negedge clk);
        checkOutput("rst_busy", busy_o, 0);
        checkOutput("rst_start", spi_start_o, 0);
        checkOutput("rst_data", spi_data_o, '0);
        checkOutput("rst_cur_id", cur_id_o, 0);
        checkOutput("rst_pulses", {gnt_o, done_o, err_o}, '0);
        rst_n = 1'b1;
        tick();
        tick();

        // All four requesters held continuously from pointer 0: 0,1,2,3,0.
        hold_mode = 1'b1;
        for (int j = 0; j < NR; j++) data_i[j*DW +: DW] = DW'(8'hC0 + j);
        resetTrack();
        req_i = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            e.id   = j % NR;
            e.data = DW'(8'hC0 + e.id);
            sb_q.push_back(e);
        end
        waitIdle("hold_all", 2000);
        hold_mode = 1'b0;
        checkOutput("hold_all_dones", dones, 5);
        checkOutput("hold_all_gap_min", min_gap, GAP_N + 1);
        checkOutput("hold_all_gap_max", max_gap, GAP_N + 1);

        foreach (vecs[i]) applyStimulus(vecs[i], $sformatf("vec%0d", i));

        // Reset during BUSY: outputs clear at once, pending req_i[2] wins afterwards.
        data_i = '0;
        data_i[0*DW +: DW] = DW'(8'h71);
        data_i[2*DW +: DW] = DW'(8'h72);
        resetTrack();
        req_i  = 4'b0001;
        e.id   = 0;
        e.data = DW'(8'h71);
        sb_q.push_back(e);
        k = 0;
        while (!in_xfer && k < 10) begin
            tick();
            k++;
        end
        checkOutput("rst_mid_grant_seen", in_xfer, 1);
        repeat (3) tick();
        checkOutput("rst_mid_in_busy", busy_o, 1);
        req_i[2] = 1'b1;
        rst_n    = 1'b0;
        #1;
        checkOutput("rst_mid_start", spi_start_o, 0);
        checkOutput("rst_mid_busy", busy_o, 0);
        checkOutput("rst_mid_data", spi_data_o, '0);
        checkOutput("rst_mid_cur_id", cur_id_o, 0);
        checkOutput("rst_mid_pulses", {gnt_o, done_o, err_o}, '0);
        in_xfer      = 1'b0;
        slave_cnt    = 0;
        fin_cnt      = 0;
        spi_finish_i = 1'b0;
        sb_q.delete();
        tick();
        checkOutput("rst_mid_hold", {busy_o, gnt_o, done_o, err_o}, '0);
        rst_n = 1'b1;
        resetTrack();
        e.id   = 2;
        e.data = DW'(8'h72);
        sb_q.push_back(e);
        waitIdle("after_rst", 1000);
        checkOutput("after_rst_grants", grants_seen, 1);
        checkOutput("after_rst_dones", dones, 1);
        checkOutput("after_rst_latency", first_gnt_cycle - start_cycle, 1);

`ifdef SPI_ARB_TIMEOUT_EN
        // Slave never finishes: watchdog aborts the transfer for requester 1.
        slave_en   = 1'b0;
        expect_err = 1'b1;
        data_i[1*DW +: DW] = DW'(8'h81);
        resetTrack();
        req_i  = 4'b0010;
        e.id   = 1;
        e.data = DW'(8'h81);
        sb_q.push_back(e);
        waitIdle("timeout", 1000);
        checkOutput("timeout_errs", errs, 1);
        checkOutput("timeout_no_done", dones, 0);
        checkOutput("timeout_err_cycle", last_err_cycle - first_gnt_cycle, TMO + 1);
        checkOutput("timeout_idle", busy_o, 0);
        slave_en   = 1'b1;
        expect_err = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
